// File: rtl/disp_arb_pkg.sv
// Shared types and constants for the display request arbiter.
// Holds the state encoding, the reset constants and the requester-index width helper.
package disp_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DISP_DATA_RST = 0;
  localparam int RR_PTR_RST    = 0;

  // A single requester still needs a one-bit index.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/disp_rr_picker.sv
// Combinational round-robin picker: first set req at or above ptr, wrapping.
// Written generically so other shared-resource arbiters can reuse it.
module disp_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_req
);

  int idx;

  // Scan from the farthest offset down so the nearest set bit is written last.
  always_comb begin
    winner = '0;
    idx    = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (req[IDX_W'(idx)]) winner = IDX_W'(idx);
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/display_request_arbiter.sv
// Round-robin sharing of the hex display with a minimum hold time per grant.
// Optional macro DISP_PREEMPT_EN makes requester 0 a preempting priority requester.
module display_request_arbiter
  import disp_arb_pkg::*;
#(
  parameter int  NUM_REQ     = 4,
  parameter int  DATA_W      = 7,
  parameter int  HOLD_CYCLES = 50000000,
  localparam int CNT_W       = $clog2(HOLD_CYCLES + 1),
  localparam int IDX_W       = idx_w(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         disp_data,
  output logic                      disp_valid,
  output logic [IDX_W-1:0]          disp_owner,
  output logic                      busy
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   winner;
  logic               any_req;
  logic               preempt;
  logic               grant;
  logic [DATA_W-1:0]  sel_data;

  disp_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (req),
    .ptr     (ptr),
    .winner  (pick),
    .any_req (any_req)
  );

`ifdef DISP_PREEMPT_EN
  assign preempt = (state == HOLD) && req[0] && (disp_owner != '0);
`else
  assign preempt = 1'b0;
`endif

  assign grant  = preempt || (any_req && ((state == IDLE) || (cnt == '0)));
  assign winner = preempt ? '0 : pick;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= IDX_W'(RR_PTR_RST);
      ack        <= '0;
      disp_data  <= DATA_W'(DISP_DATA_RST);
      disp_valid <= 1'b0;
      disp_owner <= '0;
      busy       <= 1'b0;
    end else begin
      ack <= '0;
      if (grant) begin
        ack[winner] <= 1'b1;
        disp_data   <= sel_data;
        disp_owner  <= winner;
        disp_valid  <= 1'b1;
        cnt         <= CNT_W'(HOLD_CYCLES - 1);
        ptr         <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
        state       <= HOLD;
        busy        <= 1'b1;
      end else if (state == HOLD) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/display_request_arbiter.md
Name: display_request_arbiter

Overview:
- Shares the single two-digit hex display between NUM_REQ requesters, such as UART TX byte, TX status and debug counters.
- Round-robin arbitration with a req/ack handshake.
- The granted value is held on disp_data for a minimum of HOLD_CYCLES clocks so a human can read it.
- disp_data drives data_in of the seven-segment decoder directly.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 7, width of each display value; matches decoder data_in.
- HOLD_CYCLES, 50000000, minimum display time per grant in clocks (1 s at 50 MHz). Must be >= 1.
- CNT_W, $clog2(HOLD_CYCLES+1), hold counter width. Derived; not overridden.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  level request per requester.
- req_data  in  NUM_REQ*DATA_W  value per requester; slice i = [i*DATA_W +: DATA_W].
- ack  out  NUM_REQ  one-cycle grant pulse, one-hot or zero.
- disp_data  out  DATA_W  registered value to the decoder.
- disp_valid  out  1  high once any value has been displayed since reset.
- disp_owner  out  $clog2(NUM_REQ)  index of the requester that owns disp_data.
- busy  out  1  high while in HOLD.

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; ack=0, disp_data=0, disp_valid=0, disp_owner=0, busy=0, hold counter=0.
  - RR pointer=0, so requester 0 has top priority first.
- States: IDLE and HOLD.
- Winner selection: the first set req[i] searching from the RR pointer upward, wrapping modulo NUM_REQ.
- Grant edge. Occurs on an edge in IDLE with |req=1, or an edge in HOLD with counter==0 and |req=1. On that edge:
  - disp_data <= req_data slice of the winner; disp_owner <= winner; disp_valid <= 1.
  - ack[winner] <= 1 for exactly one cycle.
  - counter <= HOLD_CYCLES-1; state <= HOLD; RR pointer <= (winner+1) mod NUM_REQ.
- Latency: req sampled high at edge N gives ack and the new disp_data visible after edge N, i.e. one cycle.
- HOLD:
  - Counter decrements each cycle; busy=1.
  - At counter==0 with no req, go to IDLE and set busy=0.
  - At counter==0 with a req pending, grant back-to-back with no idle cycle.
  - Each value is therefore shown for exactly HOLD_CYCLES cycles when another request is pending.
- IDLE: disp_data, disp_owner and disp_valid retain their last values. The display never blanks after the first grant.
- Handshake rules:
  - Requesters hold req and req_data stable until ack, then drop req in the ack cycle.
  - req still high on the edge after ack counts as a new request. It is served only after other pending requesters, per RR.
  - req dropped before ack means the request is withdrawn; no ack is issued.
  - req_data is sampled only at the grant edge. Changes during HOLD have no effect.
- Simultaneous requests: only one ack per grant edge. The losers stay pending and are served in RR order.
- HOLD_CYCLES=1: counter loads 0, so a grant is possible on every edge while requests are pending.
- Reset mid-HOLD: immediate return to reset values, with ack forced to 0 asynchronously.

Optional Feature:
- Macro: DISP_PREEMPT_EN.
- Defined:
  - req[0] is a priority requester.
  - If req[0]=1 in HOLD and disp_owner!=0, the hold terminates. The next edge is a grant edge with requester 0 as winner regardless of the RR pointer.
  - The RR pointer still updates to 1.
  - Requester 0 cannot preempt itself.
- Undefined: strictly non-preemptive RR as above. Requester 0 has no special treatment.

Decomposition:
- Package disp_arb_pkg:
  - state typedef (IDLE, HOLD).
  - Reset constants for disp_data and the RR pointer.
  - Function for the requester-index width.
- Sub-module disp_rr_picker: combinational. Inputs req and pointer; outputs winner index and any_req. Reused by other shared-resource arbiters.

Test Plan (NUM_REQ=4, HOLD_CYCLES=4):
- Single request: req[2]=1 with data 7'h35 from IDLE -> ack[2] for 1 cycle after the next edge; disp_data=7'h35, disp_owner=2, busy high 4 cycles, then IDLE.
- Contention: req[1] and req[3] rise together, data 7'h11 and 7'h33 -> grant 1 first (7'h11), grant 3 exactly 4 cycles later (7'h33), no idle gap.
- Fairness: req[0..3] held continuously -> grant order 0,1,2,3,0,…; each ack spaced 4 cycles.
- Withdrawal: req[2] drops during another owner's HOLD -> no ack[2]; IDLE after hold, disp_data retains the last value.
- Reset mid-HOLD: reset low at hold cycle 2 -> disp_data=0, disp_valid=0, ack=0, busy=0 immediately; after release, req[0] wins first.
- DISP_PREEMPT_EN: owner 3 in HOLD at cycle 1 when req[0] rises -> ack[0] on the next edge, disp_owner=0. With the macro undefined, ack[0] only after the hold expires.
